// File: rtl/phase_speed_avg_if.sv
// rtl/phase_speed_avg_if.sv - phase beat input and speed result bundle for phase_speed_avg
interface phase_speed_avg_if #(
    parameter int NCH     = 2,
    parameter int PHASE_W = 19,
    parameter int SPEED_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NCH*PHASE_W-1:0]   phase;
    logic [3:0]               meanlen;
    logic [NCH*SPEED_W-1:0]   speed;
    logic                     out_valid;
    logic [NCH-1:0]           sat;

    modport master (
        output in_valid, phase, meanlen,
        input  in_ready, speed, out_valid, sat
    );

    modport slave (
        input  in_valid, phase, meanlen,
        output in_ready, speed, out_valid, sat
    );
endinterface

// File: rtl/phase_speed_avg.sv
// rtl/phase_speed_avg.sv - multi-channel windowed phase average scaled and saturated to speed
module phase_speed_avg #(
    parameter int NCH     = 2,
    parameter int PHASE_W = 19,
    parameter int SPEED_W = 16,
    parameter int MAXLOG  = 11,
    parameter int SCALE   = 18026,
    parameter int SHIFT   = 17
) (
    input  logic            clock,
    input  logic            reset,
    phase_speed_avg_if.slave bus
);
    localparam int AW = PHASE_W + MAXLOG;
    localparam int PW = PHASE_W + 18;
    localparam int CW = MAXLOG + 1;

    localparam logic signed [PW-1:0] SCALE_S = PW'(SCALE);
    localparam logic signed [PW-1:0] SMAX    = PW'((1 << (SPEED_W - 1)) - 1);
    localparam logic signed [PW-1:0] SMIN    = ~SMAX;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_MUL, S_OUT} state_t;

    state_t state, state_next;

    logic [CW-1:0]              cnt;
    logic [3:0]                 len;
    logic signed [AW-1:0]       acc  [NCH];
    logic signed [PW-1:0]       prod [NCH];
    logic [NCH*SPEED_W-1:0]     speed_q;
    logic [NCH-1:0]             sat_q;
    logic                       out_valid_q;
    logic                       in_ready_q;

    logic                       accept;
    logic                       last_beat;
    logic                       start_win;
    logic [3:0]                 len_next;
    logic signed [PHASE_W-1:0]  ph   [NCH];
    logic signed [PHASE_W-1:0]  avg  [NCH];
    logic signed [PW-1:0]       mul  [NCH];
    logic signed [PW-1:0]       q    [NCH];
    logic [NCH*SPEED_W-1:0]     spd_next;
    logic [NCH-1:0]             sat_next;

    assign accept    = bus.in_valid && in_ready_q;
    assign last_beat = accept && (cnt == CW'(1));
    assign len_next  = (bus.meanlen > 4'(MAXLOG)) ? 4'(MAXLOG) : bus.meanlen;
    // a window starts on every entry into ACC, from IDLE after reset or from OUT
    assign start_win = (state_next == S_ACC) && (state != S_ACC);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.speed     = speed_q;
    assign bus.sat       = sat_q;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_ACC;
            S_ACC:   if (last_beat) state_next = S_MUL;
            S_MUL:   state_next = S_OUT;
            S_OUT:   state_next = S_ACC;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        spd_next = '0;
        sat_next = '0;
        for (int c = 0; c < NCH; c++) begin
            ph[c]  = bus.phase[c*PHASE_W +: PHASE_W];
            // the mean of PHASE_W-bit samples always fits back into PHASE_W bits
            avg[c] = PHASE_W'(acc[c] >>> len);
            mul[c] = PW'(avg[c]) * SCALE_S;
            q[c]   = prod[c] >>> SHIFT;
            if (q[c] > SMAX) begin
                spd_next[c*SPEED_W +: SPEED_W] = SMAX[SPEED_W-1:0];
                sat_next[c] = 1'b1;
            end else if (q[c] < SMIN) begin
                spd_next[c*SPEED_W +: SPEED_W] = SMIN[SPEED_W-1:0];
                sat_next[c] = 1'b1;
            end else begin
                spd_next[c*SPEED_W +: SPEED_W] = q[c][SPEED_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            len         <= '0;
            speed_q     <= '0;
            sat_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                acc[c]  <= '0;
                prod[c] <= '0;
            end
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next == S_ACC);
            out_valid_q <= (state == S_OUT);
            if (start_win) begin
                len <= len_next;
                cnt <= CW'(1) << len_next;
                for (int c = 0; c < NCH; c++) acc[c] <= '0;
            end else if (accept) begin
                cnt <= cnt - CW'(1);
                for (int c = 0; c < NCH; c++) acc[c] <= acc[c] + AW'(ph[c]);
            end
            if (state == S_MUL) begin
                for (int c = 0; c < NCH; c++) prod[c] <= mul[c];
            end
            if (state == S_OUT) begin
                speed_q <= spd_next;
                sat_q   <= sat_next;
            end
        end
    end
endmodule
